// File: rtl/uart_tx_fifo_if.sv
// Host-side push port and uart_txx launch handshake for uart_tx_fifo.
// The slave modport is the FIFO; the master modport is host logic plus the transmitter.
interface uart_tx_fifo_if #(
  parameter int ADDR_W = 4
);
  logic              i_wr_en;
  logic [7:0]        i_wr_data;
  logic              o_full;
  logic              o_empty;
  logic [ADDR_W:0]   o_count;
  logic              o_overflow;
  logic              o_tx_dv;
  logic [7:0]        o_tx_byte;
  logic              i_tx_active;
  logic              i_tx_done;
  logic              o_busy;

  modport slave (
    input  i_wr_en, i_wr_data, i_tx_active, i_tx_done,
    output o_full, o_empty, o_count, o_overflow, o_tx_dv, o_tx_byte, o_busy
  );

  modport master (
    output i_wr_en, i_wr_data, i_tx_active, i_tx_done,
    input  o_full, o_empty, o_count, o_overflow, o_tx_dv, o_tx_byte, o_busy
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Circular byte FIFO feeding uart_txx: queues host pushes and launches one
// frame at a time over the tx_dv / active / done handshake.
module uart_tx_fifo #(
  parameter int ADDR_W = 4
) (
  input  logic          clk,
  input  logic          rst,
  uart_tx_fifo_if.slave bus
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] LAUNCH    = 2'd1;
  localparam logic [1:0] WAIT_DONE = 2'd2;

  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              overflow_q, overflow_d;
  logic              tx_dv_q, tx_dv_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic [1:0]        state_q, state_d;

  logic push;
  logic pop;

  // Fullness is judged on registered state, so a pop on the same edge never rescues a push.
  assign push = bus.i_wr_en && !full_q;
  assign pop  = (state_q == IDLE) && !empty_q && !bus.i_tx_active;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = bus.i_wr_en && full_q;
    if (push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (ADDR_W+1)'(1);
      2'b01:   count_d = count_q - (ADDR_W+1)'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == FULL_CNT);
    empty_d = (count_d == '0);
  end

  always_comb begin
    state_d   = state_q;
    tx_dv_d   = tx_dv_q;
    tx_byte_d = tx_byte_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          tx_dv_d   = 1'b1;
          tx_byte_d = mem_q[rd_ptr_q];
          state_d   = LAUNCH;
        end
      end
      LAUNCH: begin
        // Level handshake: keep requesting until the transmitter reports active.
        if (bus.i_tx_active) begin
          tx_dv_d = 1'b0;
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (bus.i_tx_done) state_d = IDLE;
      end
      default: begin
        tx_dv_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.i_wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      tx_dv_q    <= 1'b0;
      tx_byte_q  <= '0;
      state_q    <= IDLE;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
      tx_dv_q    <= tx_dv_d;
      tx_byte_q  <= tx_byte_d;
      state_q    <= state_d;
    end
  end

  assign bus.o_full     = full_q;
  assign bus.o_empty    = empty_q;
  assign bus.o_count    = count_q;
  assign bus.o_overflow = overflow_q;
  assign bus.o_tx_dv    = tx_dv_q;
  assign bus.o_tx_byte  = tx_byte_q;
  assign bus.o_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: queue-based reference model compared
// every cycle, a stub transmitter, and directed scenarios with literal checks.
module tb_uart_tx_fifo;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;
  localparam int FRAME  = 20;

  logic clk = 1'b0;
  logic rst;
  always #2 clk = ~clk;

  uart_tx_fifo_if #(.ADDR_W(ADDR_W)) bus ();

  uart_tx_fifo #(.ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a byte queue plus the three-phase launch sequence.
  logic [7:0] q [$];
  int         m_st;
  logic       m_dv;
  logic [7:0] m_byte;
  logic       m_ov;
  bit         m_was_full;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_st   = 0;
      m_dv   = 1'b0;
      m_byte = 8'h00;
      m_ov   = 1'b0;
    end else begin
      m_was_full = (q.size() == DEPTH);
      m_ov = bus.i_wr_en && m_was_full;
      case (m_st)
        0: if (q.size() > 0 && !bus.i_tx_active) begin
             m_byte = q.pop_front();
             m_dv   = 1'b1;
             m_st   = 1;
           end
        1: if (bus.i_tx_active) begin
             m_dv = 1'b0;
             m_st = 2;
           end
        default: if (bus.i_tx_done) m_st = 0;
      endcase
      if (bus.i_wr_en && !m_was_full) q.push_back(bus.i_wr_data);
    end
  end

  // Stub transmitter state and the log of bytes it accepted.
  bit         auto_tx;
  int         sp;
  int         sc;
  logic [7:0] txlog [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    chk("count",    32'(bus.o_count),    32'(q.size()));
    chk("full",     32'(bus.o_full),     32'(q.size() == DEPTH));
    chk("empty",    32'(bus.o_empty),    32'(q.size() == 0));
    chk("overflow", 32'(bus.o_overflow), 32'(m_ov));
    chk("tx_dv",    32'(bus.o_tx_dv),    32'(m_dv));
    chk("tx_byte",  32'(bus.o_tx_byte),  32'(m_byte));
    chk("busy",     32'(bus.o_busy),     32'(m_st != 0));
    if (auto_tx) begin
      bus.i_tx_done = 1'b0;
      case (sp)
        0: if (bus.o_tx_dv) begin
             sp = 1;
             sc = 1;
           end
        1: begin
             sc--;
             if (sc == 0) begin
               bus.i_tx_active = 1'b1;
               txlog.push_back(bus.o_tx_byte);
               sc = FRAME;
               sp = 2;
             end
           end
        default: begin
             sc--;
             if (sc == 0) begin
               bus.i_tx_active = 1'b0;
               bus.i_tx_done   = 1'b1;
               sp = 0;
             end
           end
      endcase
    end
  endtask

  task automatic push1(input logic [7:0] b);
    bus.i_wr_en   = 1'b1;
    bus.i_wr_data = b;
    tick();
    bus.i_wr_en   = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while ((q.size() != 0 || m_st != 0 || sp != 0) && g < 3000) begin
      tick();
      g++;
    end
    checks++;
    if (g >= 3000) begin
      errors++;
      $display("FAIL drain_timeout: got %0d cycles expected < 3000", g);
    end
  endtask

  task automatic chk_log(input string name, input logic [7:0] exp [$]);
    chk({name, "_len"}, 32'(txlog.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++)
      chk(name, (i < txlog.size()) ? 32'(txlog[i]) : 32'hFFFF_FFFF, 32'(exp[i]));
  endtask

  initial begin
    logic [7:0] exp [$];
    int n;
    int guard;

    rst = 1'b1;
    bus.i_wr_en = 1'b0;
    bus.i_wr_data = 8'h00;
    bus.i_tx_active = 1'b0;
    bus.i_tx_done = 1'b0;
    auto_tx = 1'b1;
    sp = 0;
    sc = 0;
    repeat (3) tick();
    chk("rst_empty", 32'(bus.o_empty), 32'd1);
    chk("rst_byte",  32'(bus.o_tx_byte), 32'h00);
    rst = 1'b0;
    tick();

    // 1: single byte, latency pinned by literals
    bus.i_wr_en = 1'b1;
    bus.i_wr_data = 8'hAB;
    tick();
    bus.i_wr_en = 1'b0;
    chk("s1_count_n", 32'(bus.o_count), 32'd1);
    chk("s1_dv_n",    32'(bus.o_tx_dv), 32'd0);
    tick();
    chk("s1_dv_n1",   32'(bus.o_tx_dv), 32'd1);
    chk("s1_byte",    32'(bus.o_tx_byte), 32'hAB);
    drain();
    chk("s1_empty", 32'(bus.o_empty), 32'd1);
    chk("s1_busy",  32'(bus.o_busy), 32'd0);
    exp = '{8'hAB};
    chk_log("s1_log", exp);

    // 2: fill and overflow with the transmitter held busy
    auto_tx = 1'b0;
    bus.i_tx_active = 1'b1;
    tick();
    for (int i = 0; i < 17; i++) begin
      bus.i_wr_en = 1'b1;
      bus.i_wr_data = 8'(i);
      tick();
      if (i == 15) begin
        chk("s2_full16",  32'(bus.o_full), 32'd1);
        chk("s2_count16", 32'(bus.o_count), 32'd16);
        chk("s2_noov16",  32'(bus.o_overflow), 32'd0);
      end
      if (i == 16) begin
        chk("s2_ov",      32'(bus.o_overflow), 32'd1);
        chk("s2_count17", 32'(bus.o_count), 32'd16);
      end
    end
    bus.i_wr_en = 1'b0;
    tick();
    chk("s2_ov_clear", 32'(bus.o_overflow), 32'd0);
    txlog.delete();
    bus.i_tx_active = 1'b0;
    sp = 0;
    auto_tx = 1'b1;
    drain();
    exp.delete();
    for (int i = 0; i < 16; i++) exp.push_back(8'(i));
    chk_log("s2_log", exp);

    // 3: back-to-back pushes
    txlog.delete();
    push1(8'h55);
    bus.i_wr_en = 1'b1;
    bus.i_wr_data = 8'hA5;
    tick();
    bus.i_wr_data = 8'h0F;
    tick();
    bus.i_wr_en = 1'b0;
    drain();
    exp = '{8'h55, 8'hA5, 8'h0F};
    chk_log("s3_log", exp);

    // 4: push and pop on the same edge
    txlog.delete();
    auto_tx = 1'b0;
    bus.i_tx_active = 1'b1;
    push1(8'h11);
    tick();
    bus.i_tx_active = 1'b0;
    bus.i_wr_en = 1'b1;
    bus.i_wr_data = 8'h3C;
    tick();
    bus.i_wr_en = 1'b0;
    chk("s4_count", 32'(bus.o_count), 32'd1);
    chk("s4_byte",  32'(bus.o_tx_byte), 32'h11);
    chk("s4_dv",    32'(bus.o_tx_dv), 32'd1);
    sp = 0;
    auto_tx = 1'b1;
    drain();
    exp = '{8'h11, 8'h3C};
    chk_log("s4_log", exp);

    // 5: 40 incrementing bytes across two pointer wraps
    txlog.delete();
    n = 0;
    guard = 0;
    while (n < 40 && guard < 5000) begin
      if (q.size() < 12) begin
        bus.i_wr_en = 1'b1;
        bus.i_wr_data = 8'(n);
        n++;
      end else begin
        bus.i_wr_en = 1'b0;
      end
      tick();
      guard++;
    end
    bus.i_wr_en = 1'b0;
    chk("s5_pushed", 32'(n), 32'd40);
    drain();
    exp.delete();
    for (int i = 0; i < 40; i++) exp.push_back(8'(i));
    chk_log("s5_log", exp);

    // 6: reset while a frame is in flight
    bus.i_wr_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.i_wr_data = 8'hA0 + 8'(i);
      tick();
    end
    bus.i_wr_en = 1'b0;
    guard = 0;
    while (!bus.i_tx_active && guard < 50) begin
      tick();
      guard++;
    end
    chk("s6_active_seen", 32'(bus.i_tx_active), 32'd1);
    tick();
    txlog.delete();
    rst = 1'b1;
    tick();
    chk("s6_rst_dv",    32'(bus.o_tx_dv), 32'd0);
    chk("s6_rst_empty", 32'(bus.o_empty), 32'd1);
    chk("s6_rst_count", 32'(bus.o_count), 32'd0);
    chk("s6_rst_busy",  32'(bus.o_busy), 32'd0);
    chk("s6_rst_byte",  32'(bus.o_tx_byte), 32'h00);
    repeat (2) tick();
    rst = 1'b0;
    push1(8'hC3);
    chk("s6_active_still", 32'(bus.i_tx_active), 32'd1);
    guard = 0;
    while (bus.i_tx_active && guard < 50) begin
      chk("s6_no_launch", 32'(bus.o_tx_dv), 32'd0);
      tick();
      guard++;
    end
    drain();
    exp = '{8'hC3};
    chk_log("s6_log", exp);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Byte buffer and launch sequencer that sits directly upstream of uart_txx. Host logic pushes bytes at any rate. The block queues them in a circular FIFO and hands them one at a time to the transmitter over the i_data_avail/i_databyte/o_active/o_done handshake, so back-to-back bytes go out with no software pacing. Typical use: a UART loopback with uart_rx on the line.

Parameters:
ADDR_W, 4, FIFO address width; depth DEPTH = 2**ADDR_W (default 16 entries).

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-high reset
i_wr_en  input  1  push request, one byte per cycle
i_wr_data  input  8  byte to push
o_full  output  1  FIFO holds DEPTH bytes
o_empty  output  1  FIFO holds 0 bytes
o_count  output  ADDR_W+1  current occupancy, 0..DEPTH
o_overflow  output  1  one-cycle pulse: push dropped because full
o_tx_dv  output  1  drives uart_txx i_data_avail
o_tx_byte  output  8  drives uart_txx i_databyte
i_tx_active  input  1  from uart_txx o_active
i_tx_done  input  1  from uart_txx o_done (one-cycle pulse at frame end)
o_busy  output  1  sequencer not in IDLE

Behaviour:
- Reset (async, active-high, any state):
  - wr_ptr, rd_ptr and count = 0; o_empty=1, o_full=0, o_overflow=0.
  - o_tx_dv=0, o_tx_byte=8'h00, state=IDLE, o_busy=0.
  - FIFO contents are discarded.
  - A uart_txx frame already in flight is not aborted by this block. After reset, IDLE waits for i_tx_active=0 before the next launch.
- Storage: DEPTH x 8 register array.
  - ADDR_W-bit pointers wrap naturally at DEPTH.
  - count is ADDR_W+1 bits.
  - o_full = (count==DEPTH); o_empty = (count==0). Both are registered and reflect state after the last edge.
- Push: accepted on an edge where i_wr_en=1 and o_full=0. Writes mem[wr_ptr], then wr_ptr++.
  - If i_wr_en=1 while o_full=1, the byte is dropped and o_overflow=1 on the next cycle only. Pointers and count are unchanged.
  - Fullness is judged on registered state: a push while full is dropped even if a pop occurs on the same edge.
- Pop: performed only by the sequencer IDLE→LAUNCH transition. Loads o_tx_byte<=mem[rd_ptr], then rd_ptr++.
- Simultaneous accepted push and pop: count unchanged; both pointers advance.
- Sequencer states:
  - IDLE: if o_empty=0 and i_tx_active=0, pop, set o_tx_dv<=1 and go to LAUNCH. Otherwise stay.
  - LAUNCH: hold o_tx_dv=1 and o_tx_byte stable until i_tx_active=1 is sampled. Then o_tx_dv<=0 and go to WAIT_DONE. Using a level handshake makes the launch independent of the uart_txx sampling phase.
  - WAIT_DONE: wait for i_tx_done=1, then go to IDLE. o_tx_byte holds its value until the next pop.
- o_busy=1 in LAUNCH and WAIT_DONE.
- Latency:
  - Push to empty FIFO with idle tx at edge N: count=1 after edge N; o_tx_dv=1 after edge N+1.
  - Inter-byte gap: after i_tx_done the next o_tx_dv rises within 2 cycles, provided i_tx_active=0.
- Order is strictly FIFO: no byte is duplicated or skipped across pointer wrap.
- i_tx_done seen outside WAIT_DONE is ignored.

Test Plan:
Common setup: clk period 4 ns, clks_per_bit=543. Scenarios 1, 3, 5 and 6 use uart_txx plus uart_rx in loopback. Scenarios 2 and 4 drive i_tx_active/i_tx_done directly with a stub.
1. Single byte: push 8'hAB into the empty FIFO.
   - o_tx_dv rises 2 edges after the push and falls once o_active=1.
   - uart_rx o_data_avail pulses exactly once with o_databyte=8'hAB.
   - o_empty=1 and o_busy=0 after o_done.
2. Fill and overflow: stub holds i_tx_active=1 (no launches), then push 0x00..0x10, 17 bytes.
   - After the 16th push: o_full=1, o_count=16.
   - The 17th push produces a one-cycle o_overflow pulse and count stays 16.
   - Release the stub: the bytes sent are exactly 0x00..0x0F, in order.
3. Back-to-back: push 8'h55, 8'hA5, 8'h0F on consecutive cycles.
   - uart_rx delivers 55, A5, 0F in order, exactly 3 pulses.
   - Each next o_tx_dv rises ≤2 cycles after o_done.
4. Push/pop same edge: stub with count=1 and sequencer in IDLE; push 8'h3C on the pop edge.
   - o_count stays 1 and o_tx_byte equals the older byte.
   - The next launch sends 8'h3C.
5. Wrap-around: stream 40 incrementing bytes (0x00..0x27) with pushes paced to avoid overflow.
   - Receiver gets all 40 bytes in order across two full pointer wraps.
6. Reset mid-operation: FIFO holds 5 bytes and a frame is mid-transmission; pulse rst for 3 cycles.
   - All outputs take their reset values during rst.
   - No launch occurs until o_active falls.
   - After that, a new push of 8'hC3 is the only byte sent.
